// File: rtl/gray_wptr_tx.sv
// gray_wptr_tx
// Write-side pointer logic for an asynchronous FIFO. Keeps the binary write
// pointer and publishes it in Gray code to the read domain. Computes full,
// almost_full, a conservative fill level and an overflow pulse. These are
// computed against a read pointer that has already been synchronized into
// this clock domain.
//
// Parameters
//   AW        FIFO address width (>= 2); depth = 2**AW, pointers are AW+1 bits
//   AF_LEVEL  fill level at or above which almost_full asserts (1..2**AW)
//
// Ports
//   clk               write-domain clock
//   rst_n             asynchronous active-low reset
//   wr_en             write request
//   rd_ptr_gray_sync  synchronized Gray read pointer (AW+1 bits)
//   wr_addr           registered RAM write address (AW bits)
//   wr_accept         combinational RAM write strobe, wr_en & ~full
//   wr_ptr_gray       registered Gray write pointer for the read domain
//   full              registered full flag
//   almost_full       registered level >= AF_LEVEL flag
//   wr_level          registered conservative fill level, 0..2**AW
//   overflow          registered one-cycle pulse for a rejected write

module gray_wptr_tx #(
   parameter int AW       = 4,
   parameter int AF_LEVEL = 2**AW - 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [AW:0]   rd_ptr_gray_sync,
   output logic [AW-1:0] wr_addr,
   output logic          wr_accept,
   output logic [AW:0]   wr_ptr_gray,
   output logic          full,
   output logic          almost_full,
   output logic [AW:0]   wr_level,
   output logic          overflow
);

   localparam logic [AW:0] AF_VEC = (AW+1)'(AF_LEVEL);

   logic [AW:0] wbin;
   logic [AW:0] wbin_next;
   logic [AW:0] wgray_next;
   logic [AW:0] rbin_sync;
   logic [AW:0] level_next;
   logic [AW:0] full_pattern;

   // Writes are accepted only when the registered full flag is clear, so a
   // rejected write never moves the pointer.
   assign wr_accept = wr_en & ~full;

   // Next binary pointer and its Gray encoding. Because the pointer advances
   // by at most one per cycle, the Gray value changes by at most one bit.
   // This includes the wrap from all-ones back to zero.
   assign wbin_next  = wbin + {{AW{1'b0}}, wr_accept};
   assign wgray_next = wbin_next ^ (wbin_next >> 1);

   // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      rbin_sync = '0;
      for (int i = 0; i <= AW; i++) begin
         rbin_sync[i] = ^(rd_ptr_gray_sync >> i);
      end
   end

   // The level is the unsigned pointer difference. It can only lag the true
   // occupancy, because the read pointer seen here is a few cycles old.
   assign level_next = wbin_next - rbin_sync;

   // Full when the write pointer is exactly one lap ahead of the read
   // pointer. In Gray code that is the read pointer with its top two bits
   // inverted.
   assign full_pattern = {~rd_ptr_gray_sync[AW:AW-1], rd_ptr_gray_sync[AW-2:0]};

   // All published state is registered. In particular, wr_ptr_gray comes
   // straight from a flop so the crossing into the read domain never sees
   // combinational glitches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wbin        <= '0;
         wr_addr     <= '0;
         wr_ptr_gray <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
         wr_level    <= '0;
         overflow    <= 1'b0;
      end else begin
         wbin        <= wbin_next;
         wr_addr     <= wbin_next[AW-1:0];
         wr_ptr_gray <= wgray_next;
         full        <= (wgray_next == full_pattern);
         almost_full <= (level_next >= AF_VEC);
         wr_level    <= level_next;
         overflow    <= wr_en & full;
      end
   end

endmodule

// File: doc/gray_wptr_tx.md
GRAY_WPTR_TX -- requirements
Module: gray_wptr_tx

Interface
REQ-001 Parameter: AW, default 4, FIFO address width; depth = 2**AW; pointers are AW+1 bits; AW SHALL be at least 2.
REQ-002 Parameter: AF_LEVEL, default 2**AW-1, level at or above which almost_full asserts; range 1..2**AW.
REQ-003 clk  input  1  write-domain clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 wr_en  input  1  write request, one per cycle.
REQ-006 rd_ptr_gray_sync  input  AW+1  read pointer in Gray code, already synchronized into clk domain by the two-flop pointer synchronizer.
REQ-007 wr_addr  output  AW  RAM write address, equal to binary write pointer [AW-1:0].
REQ-008 wr_accept  output  1  combinational, wr_en AND NOT full; RAM write strobe.
REQ-009 wr_ptr_gray  output  AW+1  registered Gray write pointer, driven straight into the read-domain synchronizer.
REQ-010 full  output  1  registered FIFO full flag.
REQ-011 almost_full  output  1  registered, level >= AF_LEVEL.
REQ-012 wr_level  output  AW+1  registered conservative fill level, 0..2**AW.
REQ-013 overflow  output  1  registered one-cycle pulse for a rejected write.

Function
REQ-014 Internal binary pointer wbin (AW+1 bits) SHALL increment by 1, mod 2**(AW+1), on every cycle with wr_accept=1; otherwise it SHALL hold.
REQ-015 wbin_next = wbin + wr_accept; wr_ptr_gray SHALL register wbin_next ^ (wbin_next >> 1) each cycle, so wr_ptr_gray equals Gray(wbin) one cycle after the write is accepted.
REQ-016 wr_ptr_gray SHALL be driven only from a flop, with no combinational logic after it, and SHALL change in at most one bit per clk cycle.
REQ-017 wr_addr SHALL equal wbin[AW-1:0] and SHALL be registered, updating in the same cycle as wr_ptr_gray.
REQ-018 full SHALL register (Gray(wbin_next) == {~rd_ptr_gray_sync[AW:AW-1], rd_ptr_gray_sync[AW-2:0]}).
REQ-019 rbin_sync SHALL be the Gray-to-binary conversion of rd_ptr_gray_sync (XOR prefix from the MSB); wr_level SHALL register (wbin_next - rbin_sync) mod 2**(AW+1).
REQ-020 almost_full SHALL register (wbin_next - rbin_sync) >= AF_LEVEL, using the same unsigned AW+1-bit difference.
REQ-021 overflow SHALL register (wr_en AND full); wbin SHALL NOT change on a rejected write.
REQ-022 Latency: accepted write at edge N -> wr_addr, wr_ptr_gray, full, wr_level, almost_full reflect it after edge N.
REQ-023 Latency: rd_ptr_gray_sync change before edge N -> full, wr_level, almost_full reflect it after edge N.
REQ-024 Simultaneous accepted write and read-pointer advance in one cycle SHALL both be reflected: level unchanged, and full computed from both new values.
REQ-025 Pointer wrap from 2**(AW+1)-1 to 0 SHALL be seamless; Gray wrap is 1 bit (MSB only).
REQ-026 full SHALL never deassert without a rd_ptr_gray_sync change and SHALL never assert while wr_level < 2**AW.

Reset
REQ-027 rst_n low SHALL asynchronously force wbin, wr_addr, wr_ptr_gray, wr_level, full, almost_full and overflow to 0, including mid-operation.
REQ-028 Release of rst_n SHALL take effect at the next clk edge; the first accepted write after release SHALL use wr_addr=0.

Verification (AW=2, AF_LEVEL=3, rd_ptr_gray_sync=0 unless stated)
REQ-029 Reset: assert rst_n=0 mid-stream with wr_en=1 -> all outputs 0 immediately, with no wait for a clk edge.
REQ-030 Fill: wr_en=1 for 4 cycles -> wr_ptr_gray 001,011,010,110; wr_level 1,2,3,4; almost_full at level 3; full after the 4th edge.
REQ-031 Overflow: with full=1, wr_en=1 for 2 cycles -> overflow=1 for 2 cycles; wr_ptr_gray stays 110; wr_accept=0.
REQ-032 Drain: from full, rd_ptr_gray_sync=001 -> after the next edge full=0 and wr_level=3; a simultaneous write keeps full=1 and sets wr_ptr_gray=111.
REQ-033 Wrap: 8 writes with the read pointer tracking -> wr_ptr_gray returns to 000, wr_addr sequence 0,1,2,3,0,1,2,3.
REQ-034 Property under random wr_en and legal reads: Hamming distance of consecutive wr_ptr_gray values <= 1; wr_level <= 4; overflow only when full.
